// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and monitor FSM encoding, used by the timing
// generator and the timing monitor.
package vga_pkg;

    localparam int unsigned VGA_H_SYNC_PULSE  = 96;
    localparam int unsigned VGA_H_BACK_PORCH  = 48;
    localparam int unsigned VGA_H_ACTIVE_TIME = 640;
    localparam int unsigned VGA_H_FRONT_PORCH = 16;
    localparam int unsigned VGA_H_PERIOD      = VGA_H_SYNC_PULSE + VGA_H_BACK_PORCH +
                                                VGA_H_ACTIVE_TIME + VGA_H_FRONT_PORCH;

    localparam int unsigned VGA_V_SYNC_PULSE  = 2;
    localparam int unsigned VGA_V_BACK_PORCH  = 33;
    localparam int unsigned VGA_V_ACTIVE_TIME = 480;
    localparam int unsigned VGA_V_FRONT_PORCH = 10;
    localparam int unsigned VGA_V_PERIOD      = VGA_V_SYNC_PULSE + VGA_V_BACK_PORCH +
                                                VGA_V_ACTIVE_TIME + VGA_V_FRONT_PORCH;

    localparam int unsigned POS_W     = 12;
    localparam int unsigned PIX_W     = 10;
    localparam int unsigned ERR_CNT_W = 16;

    localparam logic [POS_W-1:0] POS_MAX = '1;

    typedef enum logic [1:0] {
        StSearch,
        StCheck,
        StLocked
    } mon_state_e;

    // Position counters stick at their maximum instead of wrapping.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] val);
        return (val == POS_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registered falling-edge detector: remembers last cycle's sample and flags a 1->0 change.
module vga_edge_det (
    input  logic vga_clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_fall
);

    logic r_sig_d;

    // Reset to 0 so a sync already low when reset releases is not seen as a fresh edge.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_fall = !i_sig && r_sig_d;

endmodule

// File: rtl/vga_timing_monitor.sv
// Measures hs/vs timing against the expected line/frame periods, locks onto a clean source and
// reports per-pixel coordinates. Define VGA_MON_ERR_CNT_EN to build the violation counter.
module vga_timing_monitor
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC_PULSE   = VGA_H_SYNC_PULSE,
    parameter int unsigned H_BACK_PORCH   = VGA_H_BACK_PORCH,
    parameter int unsigned H_LINE_PERIOD  = VGA_H_PERIOD,
    parameter int unsigned V_SYNC_PULSE   = VGA_V_SYNC_PULSE,
    parameter int unsigned V_BACK_PORCH   = VGA_V_BACK_PORCH,
    parameter int unsigned V_FRAME_PERIOD = VGA_V_PERIOD
) (
    input  logic                 vga_clk,
    input  logic                 rst,
    input  logic                 hs,
    input  logic                 vs,
    input  logic                 active,
    output logic [PIX_W-1:0]     pix_x,
    output logic [PIX_W-1:0]     pix_y,
    output logic                 pix_valid,
    output logic [POS_W-1:0]     line_len,
    output logic [POS_W-1:0]     frame_lines,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [POS_W-1:0] LINE_PERIOD  = POS_W'(H_LINE_PERIOD);
    localparam logic [POS_W-1:0] FRAME_PERIOD = POS_W'(V_FRAME_PERIOD);
    localparam logic [POS_W-1:0] H_OFFSET     = POS_W'(H_SYNC_PULSE + H_BACK_PORCH);
    localparam logic [POS_W-1:0] V_OFFSET     = POS_W'(V_SYNC_PULSE + V_BACK_PORCH);

    logic             w_hs_fall;
    logic             w_vs_fall;
    logic [POS_W-1:0] r_hpos;
    logic [POS_W-1:0] r_vpos;
    logic [POS_W-1:0] w_hpos;
    logic [POS_W-1:0] w_vpos;
    logic [POS_W-1:0] w_hlen;
    logic [POS_W-1:0] w_vlen;
    logic             w_hpos_max;
    logic             w_line_bad;
    logic             w_frame_bad;
    mon_state_e       r_state;
    mon_state_e       w_state_next;
    logic             r_check_bad;
    logic             w_check_bad_next;
    logic             w_err;
    logic [POS_W-1:0] r_line_len;
    logic [POS_W-1:0] r_frame_lines;
    logic [PIX_W-1:0] r_pix_x;
    logic [PIX_W-1:0] r_pix_y;
    logic             r_pix_valid;
    logic             r_locked;

    vga_edge_det u_hs_edge (
        .vga_clk (vga_clk),
        .rst     (rst),
        .i_sig   (hs),
        .o_fall  (w_hs_fall)
    );

    vga_edge_det u_vs_edge (
        .vga_clk (vga_clk),
        .rst     (rst),
        .i_sig   (vs),
        .o_fall  (w_vs_fall)
    );

    // Position of the sample currently on the inputs.
    always_comb begin
        w_hpos = w_hs_fall ? '0 : sat_inc(r_hpos);
        if (w_vs_fall) begin
            w_vpos = '0;
        end else if (w_hs_fall) begin
            w_vpos = sat_inc(r_vpos);
        end else begin
            w_vpos = r_vpos;
        end
    end

    assign w_hlen      = r_hpos + 1'b1;
    assign w_vlen      = r_vpos + 1'b1;
    assign w_hpos_max  = (w_hpos == POS_MAX);
    assign w_line_bad  = w_hs_fall && (w_hlen != LINE_PERIOD);
    assign w_frame_bad = w_vs_fall && (w_vlen != FRAME_PERIOD);

    // r_check_bad remembers a wrong line seen since CHECK started evaluating the current frame.
    always_comb begin
        w_state_next     = r_state;
        w_check_bad_next = r_check_bad;
        w_err            = 1'b0;
        unique case (r_state)
            StSearch: begin
                if (w_hpos_max) begin
                    w_state_next = StSearch;
                end else if (w_vs_fall) begin
                    w_state_next     = StCheck;
                    w_check_bad_next = 1'b0;
                end
            end
            StCheck: begin
                if (w_hpos_max) begin
                    w_state_next = StSearch;
                end else if (w_vs_fall) begin
                    w_state_next     = (!r_check_bad && !w_line_bad && !w_frame_bad) ?
                                       StLocked : StCheck;
                    w_check_bad_next = 1'b0;
                end else if (w_line_bad) begin
                    w_check_bad_next = 1'b1;
                end
            end
            StLocked: begin
                if (w_line_bad || w_frame_bad || w_hpos_max) begin
                    w_err        = 1'b1;
                    w_state_next = StSearch;
                end
            end
            default: begin
                w_state_next = StSearch;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state       <= StSearch;
            r_check_bad   <= 1'b0;
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_line_len    <= '0;
            r_frame_lines <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_valid   <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_check_bad <= w_check_bad_next;
            r_hpos      <= w_hpos;
            r_vpos      <= w_vpos;
            if (w_hs_fall) begin
                r_line_len <= w_hlen;
            end
            if (w_vs_fall) begin
                r_frame_lines <= w_vlen;
            end
            r_pix_x     <= PIX_W'(w_hpos - H_OFFSET);
            r_pix_y     <= PIX_W'(w_vpos - V_OFFSET);
            r_pix_valid <= active && r_locked;
            r_locked    <= (w_state_next == StLocked);
        end
    end

`ifdef VGA_MON_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    // Violation is flagged in the cycle its sample is on the inputs; locked drops a cycle later.
    assign err_pulse   = w_err;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_valid   = r_pix_valid;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign locked      = r_locked;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Self-checking bench: a scaled-down timing source with random faults drives the monitor,
// and a per-sample reference model written from the timing rules predicts every output.
module tb_vga_timing_monitor;

    localparam int HS = 8;
    localparam int HB = 6;
    localparam int HA = 20;
    localparam int HF = 6;
    localparam int HL = HS + HB + HA + HF;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VL = VS + VB + VA + VF;

    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

`ifdef VGA_MON_ERR_CNT_EN
    localparam int EXP_ERR_CNT = 3;
`else
    localparam int EXP_ERR_CNT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic        active = 1'b0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic [11:0] line_len;
    logic [11:0] frame_lines;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;

    vga_timing_monitor #(
        .H_SYNC_PULSE   (HS),
        .H_BACK_PORCH   (HB),
        .H_LINE_PERIOD  (HL),
        .V_SYNC_PULSE   (VS),
        .V_BACK_PORCH   (VB),
        .V_FRAME_PERIOD (VL)
    ) u_dut (
        .vga_clk     (clk),
        .rst         (rst),
        .hs          (hs),
        .vs          (vs),
        .active      (active),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int  m_hpos, m_vpos, m_line_len, m_frame_lines, m_state, m_pix_x, m_pix_y, m_err_cnt;
    bit  m_hs_d, m_vs_d, m_pix_valid, m_locked;
    int  m_lines[$];

    task automatic model_reset();
        m_hpos = 0; m_vpos = 0; m_line_len = 0; m_frame_lines = 0; m_state = M_SEARCH;
        m_pix_x = 0; m_pix_y = 0; m_err_cnt = 0;
        m_hs_d = 0; m_vs_d = 0; m_pix_valid = 0; m_locked = 0;
        m_lines.delete();
    endtask

    task automatic model_step(input bit h, input bit v, input bit a, output bit err);
        bit hf, vf, ok;
        int plen, flen, nh, nv, ns;
        hf   = !h && m_hs_d;
        vf   = !v && m_vs_d;
        plen = (m_hpos + 1) % 4096;
        flen = (m_vpos + 1) % 4096;
        nh   = hf ? 0 : ((m_hpos < 4095) ? m_hpos + 1 : 4095);
        nv   = vf ? 0 : (hf ? ((m_vpos < 4095) ? m_vpos + 1 : 4095) : m_vpos);
        err  = 0;
        ns   = m_state;
        if (m_state == M_LOCKED) begin
            if ((hf && plen != HL) || (vf && flen != VL) || nh == 4095) begin
                err = 1;
                ns  = M_SEARCH;
            end
        end else if (nh == 4095) begin
            ns = M_SEARCH;
        end else if (m_state == M_SEARCH) begin
            if (vf) begin
                ns = M_CHECK;
                m_lines.delete();
            end
        end else begin
            if (hf) m_lines.push_back(plen);
            if (vf) begin
                ok = (flen == VL);
                foreach (m_lines[k]) if (m_lines[k] != HL) ok = 0;
                ns = ok ? M_LOCKED : M_CHECK;
                m_lines.delete();
            end
        end
        if (hf) m_line_len = plen;
        if (vf) m_frame_lines = flen;
        m_pix_x     = (nh - (HS + HB)) & 1023;
        m_pix_y     = (nv - (VS + VB)) & 1023;
        m_pix_valid = a && m_locked;
        m_locked    = (ns == M_LOCKED);
`ifdef VGA_MON_ERR_CNT_EN
        if (err && m_err_cnt < 65535) m_err_cnt++;
`endif
        m_hpos = nh; m_vpos = nv; m_state = ns; m_hs_d = h; m_vs_d = v;
    endtask

    int rst_left     = 0;
    int rst_line     = -1;
    int rst_col      = 0;
    int n_samp       = 0;
    int lock_rise_at = -1;
    int err_seen     = 0;
    int last_h       = -1;
    int last_v       = -1;
    bit px_chk_en    = 0;
    bit glitch_en    = 0;

    // One sample: drive after the edge, check before the next one, then advance the model.
    task automatic tick(input bit h, input bit v, input bit a, input int gh, input int gv);
        bit rv, e;
        rv = (rst_left > 0);
        if (rst_left > 0) rst_left--;
        @(posedge clk);
        #2;
        hs = h; vs = v; active = a; rst = rv;
        #2;
        if (rv) begin
            model_reset();
            n_samp = 0;
            check_val("rst_outs", 64'({pix_x, pix_y, pix_valid, line_len, frame_lines, locked,
                                       err_pulse, err_cnt}), 64'd0);
        end else begin
            check_val("ctl", 64'({locked, pix_valid, err_cnt}),
                      64'({m_locked, m_pix_valid, 16'(m_err_cnt)}));
            check_val("pos", 64'({pix_x, pix_y, line_len, frame_lines}),
                      64'({10'(m_pix_x), 10'(m_pix_y), 12'(m_line_len), 12'(m_frame_lines)}));
            if (px_chk_en && last_h == HS + HB && last_v == VS + VB)
                check_val("px_first", 64'({pix_x, pix_y, pix_valid}), 64'({10'd0, 10'd0, 1'b1}));
            if (px_chk_en && last_h == HS + HB + HA - 1 && last_v == VS + VB + VA - 1)
                check_val("px_last", 64'({pix_x, pix_y, pix_valid}),
                          64'({10'(HA - 1), 10'(VA - 1), 1'b1}));
            if (lock_rise_at < 0 && locked === 1'b1) lock_rise_at = n_samp;
            model_step(h, v, a, e);
            check_val("err_pulse", 64'(err_pulse), 64'(e));
            if (err_pulse === 1'b1) err_seen++;
            n_samp++;
        end
        last_h = gh;
        last_v = gv;
    endtask

    task automatic gen_line(input int v, input int len);
        bit act;
        for (int i = 0; i < len; i++) begin
            if (v == rst_line && i == rst_col) begin
                rst_left = 3;
                rst_line = -1;
            end
            act = (i >= HS + HB) && (i < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            if (glitch_en && $urandom_range(0, 15) == 0) act = !act;
            tick(i >= HS, v >= VS, act, i, v);
        end
    endtask

    task automatic gen_frame(input int nlines, input int bad_v, input int bad_len);
        for (int v = 0; v < nlines; v++) gen_line(v, (v == bad_v) ? bad_len : HL);
    endtask

    task automatic gen_hold(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic gen_frame_rand();
        int nl;
        nl = ($urandom_range(0, 5) == 0) ? VL - 1 + int'($urandom_range(0, 2)) : VL;
        if ($urandom_range(0, 9) == 0) begin
            rst_line = int'($urandom_range(0, VL - 1));
            rst_col  = int'($urandom_range(0, HL - 1));
        end
        for (int v = 0; v < nl; v++)
            gen_line(v, ($urandom_range(0, 19) == 0) ? HL - 2 + int'($urandom_range(0, 4)) : HL);
    endtask

    int e0;

    initial begin
        model_reset();
        rst_left = 3;
        gen_hold(3);

        // Source and monitor leave reset together; lock after the second vs fall.
        gen_frame(VL, -1, 0);
        gen_frame(VL, -1, 0);
        check_val("lock_early", 64'(locked), 64'd0);
        px_chk_en = 1;
        gen_frame(VL, -1, 0);
        px_chk_en = 0;
        check_val("lock_sample", 64'(lock_rise_at), 64'(2 * HL * VL + 1));
        check_val("locked", 64'(locked), 64'd1);
        check_val("line_len", 64'(line_len), 64'(HL));
        check_val("frame_lines", 64'(frame_lines), 64'(VL));

        // One short line while locked.
        e0 = err_seen;
        gen_frame(VL, 7, HL - 1);
        check_val("short_err", 64'(err_seen - e0), 64'd1);
        check_val("short_unlock", 64'(locked), 64'd0);
        gen_frame(VL, -1, 0);
        gen_frame(VL, -1, 0);
        gen_line(0, HL);
        check_val("short_relock", 64'(locked), 64'd1);

        // hs stuck high while locked.
        e0 = err_seen;
        gen_hold(4200);
        check_val("hold_err", 64'(err_seen - e0), 64'd1);
        check_val("hold_unlock", 64'(locked), 64'd0);
        gen_frame(VL, -1, 0);
        gen_frame(VL, -1, 0);
        gen_line(0, HL);
        check_val("hold_relock", 64'(locked), 64'd1);

        // Reset mid-frame: needs two fresh vs falls.
        gen_frame(VL, -1, 0);
        rst_line = 5;
        rst_col  = 10;
        gen_frame(VL, -1, 0);
        check_val("rst_nolock_a", 64'(locked), 64'd0);
        gen_frame(VL, -1, 0);
        check_val("rst_nolock_b", 64'(locked), 64'd0);
        gen_line(0, HL);
        check_val("rst_relock", 64'(locked), 64'd1);

        // Randomized faults, glitches and resets, checked by the model on every sample.
        glitch_en = 1;
        for (int f = 0; f < 30; f++) gen_frame_rand();
        glitch_en = 0;
        rst_line  = -1;

        // Exactly three violations after a clean reset.
        rst_left = 2;
        gen_hold(2);
        gen_frame(VL, -1, 0);
        gen_frame(VL, -1, 0);
        for (int k = 0; k < 3; k++) begin
            gen_frame(VL, 7, HL - 1);
            gen_frame(VL, -1, 0);
            gen_frame(VL, -1, 0);
        end
        check_val("err_cnt", 64'(err_cnt), 64'(EXP_ERR_CNT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter H_SYNC_PULSE, default 96, hs low-pulse width in pixel clocks.
REQ-002 Parameter H_BACK_PORCH, default 48, clocks from end of hs pulse to first active pixel.
REQ-003 Parameter H_LINE_PERIOD, default 800, expected clocks per line.
REQ-004 Parameter V_SYNC_PULSE, default 2, vs low-pulse width in lines.
REQ-005 Parameter V_BACK_PORCH, default 33, lines from end of vs pulse to first active line.
REQ-006 Parameter V_FRAME_PERIOD, default 525, expected lines per frame.
REQ-007 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 hs  input  1  horizontal sync, active-low, synchronous to vga_clk.
REQ-010 vs  input  1  vertical sync, active-low, synchronous to vga_clk.
REQ-011 active  input  1  display-enable from the timing source.
REQ-012 pix_x, pix_y  output  10 each  coordinates of the previous-cycle input sample.
REQ-013 pix_valid  output  1  the previous-cycle sample is an active pixel while locked.
REQ-014 line_len, frame_lines  output  12 each  last measured line length (clocks) and frame length (lines).
REQ-015 locked  output  1  the timing matches the parameters.
REQ-016 err_pulse  output  1  one-cycle pulse on a timing violation.
REQ-017 err_cnt  output  16  count of timing violations.

Function
REQ-018 hs_fall = !hs && hs_d; vs_fall = !vs && vs_d; hs_d and vs_d are the previous-cycle samples.
REQ-019 Internal hpos (12b) SHALL be 0 on a hs_fall sample, otherwise the previous hpos+1, saturating at 4095.
REQ-020 Internal vpos (12b) SHALL be 0 on a vs_fall sample, +1 on a hs_fall sample without vs_fall, otherwise held; it saturates at 4095. A simultaneous hs_fall and vs_fall gives 0.
REQ-021 On hs_fall, line_len SHALL load the previous hpos+1; on vs_fall, frame_lines SHALL load the previous vpos+1.
REQ-022 FSM states: SEARCH, CHECK, LOCKED.
  SEARCH->CHECK on vs_fall.
  CHECK->LOCKED on the next vs_fall if the completed frame had V_FRAME_PERIOD lines and every line in it was H_LINE_PERIOD long. Otherwise CHECK stays in CHECK and restarts its evaluation.
REQ-023 In LOCKED, violations are: hs_fall with line length != H_LINE_PERIOD; vs_fall with frame length != V_FRAME_PERIOD; hpos reaching 4095.
  On any violation, err_pulse SHALL be 1 for one cycle and the FSM goes to SEARCH in the same cycle.
REQ-024 In SEARCH or CHECK, hpos reaching 4095 SHALL force SEARCH without err_pulse.
REQ-025 locked SHALL be registered and equal to (state==LOCKED).
REQ-026 pix_x SHALL be registered as hpos-(H_SYNC_PULSE+H_BACK_PORCH), truncated to 10 bits.
  pix_y SHALL be registered as vpos-(V_SYNC_PULSE+V_BACK_PORCH), truncated to 10 bits.
  pix_valid SHALL be registered as active && locked. Latency is one cycle.
REQ-027 Arithmetic SHALL use 12-bit unsigned values; comparisons use full width.

Reset
REQ-028 On rst: all outputs 0, hpos=vpos=0, hs_d=vs_d=0 (no false edge mid-pulse), state=SEARCH.
REQ-029 A reset asserted mid-frame SHALL abandon all measurements; re-lock requires two new vs_fall events.

Configuration
REQ-030 With macro VGA_MON_ERR_CNT_EN defined, err_cnt SHALL increment on each err_pulse, saturating at 16'hFFFF, and clear only on rst.
REQ-031 Without VGA_MON_ERR_CNT_EN, err_cnt SHALL be constant 0 and no counter register is built; err_pulse is unaffected.

Structure
REQ-032 Shared package vga_pkg SHALL hold the 640x480 timing constants (H_/V_ SYNC, BACK_PORCH, ACTIVE_TIME, FRONT_PORCH, PERIOD) and the FSM state encoding. Both the timing generator and this block use these constants.
REQ-033 One sub-module SHALL be built: vga_edge_det (registered falling-edge detector), instantiated for hs and vs; all other logic is flat.

Verification
REQ-034 Drive the block from the 640x480 timing generator, both leaving reset together. Required response: locked rises one cycle after the second vs_fall (sample 840000); line_len=800; frame_lines=525.
REQ-035 With the block locked, the first active sample (generator h=144, v=35) SHALL give pix_x=0, pix_y=0, pix_valid=1 one cycle later. Sample h=783, v=514 SHALL give pix_x=639, pix_y=479.
REQ-036 With the block locked, shorten one line to 799 clocks. Required response: err_pulse for one cycle at that hs_fall, locked=0 one cycle later, and locked back after two more clean frames.
REQ-037 Hold hs high for 4200 cycles while locked. Required response: err_pulse at hpos=4095 and state SEARCH.
REQ-038 Assert rst mid-frame for 3 cycles. Required response: all outputs 0 and re-lock after two vs_fall.
REQ-039 Inject 3 violations with VGA_MON_ERR_CNT_EN defined: err_cnt=3. Without the macro: err_cnt=0.
